// File: rtl/clock_period_meter_pkg.sv
// Shared types and default constants for the clock period meter.
package clock_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam int CNT_W_DEF       = 28;
  localparam int TIMEOUT_DEF     = 200000000;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-flop
// history register producing single-cycle rise/fall pulses.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_p,
  output logic fall_p,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   hist;

  // Synchronizer chain and edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
      hist       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
      hist       <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign level  = sync_chain[SYNC_STAGES-1];
  assign rise_p = level & ~hist;
  assign fall_p = ~level & hist;

endmodule

// File: rtl/clock_period_meter.sv
// Measures high time and full period of a slow asynchronous square wave in
// clk cycles, with a one-cycle result strobe and a sticky stall timeout.
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int          SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_reg;
  logic             rise_p;
  logic             fall_p;
  logic             sig_level;
  logic             rise_q;
  logic             at_limit;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_front (
    .clk     (clk),
    .reset   (reset),
    .async_in(sig_in),
    .rise_p  (rise_p),
    .fall_p  (fall_p),
    .level   (sig_level)
  );

  assign rise_q   = rise_p & sig_level;
  assign at_limit = (cnt == TIMEOUT_C);

  // Measurement FSM, duration counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_reg     <= '0;
      high_time  <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        cnt     <= '0;
        timeout <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
            busy  <= 1'b1;
          end
          // A qualifying edge in the limit cycle takes priority over timeout
          ARM: begin
            if (rise_q) begin
              cnt   <= CNT_ONE;
              state <= MEAS_HIGH;
            end else if (at_limit) begin
              timeout <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          MEAS_HIGH: begin
            if (fall_p) begin
              hi_reg <= cnt;
              cnt    <= CNT_ONE;
              state  <= MEAS_LOW;
            end else if (at_limit) begin
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          MEAS_LOW: begin
            if (rise_q) begin
              high_time  <= hi_reg;
              period     <= {1'b0, hi_reg} + {1'b0, cnt};
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              cnt        <= CNT_ONE;
              state      <= MEAS_HIGH;
            end else if (at_limit) begin
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
